// File: rtl/multicycle_controller.sv
// Multicycle FSM controller: fetch/decode/execute/memory/writeback
// sequencing with an NZCV register and ARM condition gating.
module multicycle_controller #(
   parameter int ALUCTRL_W = 3,
   parameter bit COND_EN   = 1'b1,
   parameter bit BRANCH_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          inst,
   input  logic [3:0]           ALUFlags,
   input  logic                 mem_ready,
   output logic                 PCWrite,
   output logic                 IRWrite,
   output logic                 AdrSrc,
   output logic                 MemWrite,
   output logic                 MemtoReg,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ImmSrc,
   output logic [1:0]           RegSrc,
   output logic                 RegWrite,
   output logic                 shiftSrc,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic [3:0]           flags,
   output logic                 illegal
);

   typedef enum logic [3:0] {
      FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADR,
      MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH
   } state_t;

   state_t     state;
   logic [3:0] nzcv;

   logic [3:0] cond;
   logic [1:0] op;
   logic       ibit;
   logic [3:0] cmd;
   logic       sbit;
   logic       unused_bits;

   assign cond        = inst[31:28];
   assign op          = inst[27:26];
   assign ibit        = inst[25];
   assign cmd         = inst[24:21];
   assign sbit        = inst[20];
   assign unused_bits = ^inst[19:0];

   logic n, z, c, v;
   assign {n, z, c, v} = nzcv;

   logic cond_pass;
   logic condex;

   always_comb begin
      cond_pass = 1'b1;
      unique case (cond)
         4'b0000: cond_pass = z;
         4'b0001: cond_pass = !z;
         4'b0010: cond_pass = c;
         4'b0011: cond_pass = !c;
         4'b0100: cond_pass = n;
         4'b0101: cond_pass = !n;
         4'b0110: cond_pass = v;
         4'b0111: cond_pass = !v;
         4'b1000: cond_pass = c && !z;
         4'b1001: cond_pass = !c || z;
         4'b1010: cond_pass = (n == v);
         4'b1011: cond_pass = (n != v);
         4'b1100: cond_pass = !z && (n == v);
         4'b1101: cond_pass = z || (n != v);
         default: cond_pass = 1'b1;
      endcase
   end

   assign condex = COND_EN ? cond_pass : 1'b1;

   logic       cmd_ok;
   logic       is_cmp;
   logic       is_mov;
   logic [2:0] alu_op;

   always_comb begin
      cmd_ok = 1'b1;
      is_cmp = 1'b0;
      is_mov = 1'b0;
      alu_op = 3'b000;
      unique case (cmd)
         4'b0100: alu_op = 3'b000;
         4'b0010: alu_op = 3'b001;
         4'b0000: alu_op = 3'b100;
         4'b1100: alu_op = 3'b101;
         4'b1010: begin
            alu_op = 3'b001;
            is_cmp = 1'b1;
         end
         4'b1101: begin
            alu_op = 3'b000;
            is_mov = 1'b1;
         end
         default: cmd_ok = 1'b0;
      endcase
   end

   logic op_ok;
   assign op_ok = (op == 2'b00) || (op == 2'b01) ||
                  ((op == 2'b10) && BRANCH_EN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
         nzcv  <= 4'b0000;
      end else begin
         unique case (state)
            FETCH:
               if (mem_ready) state <= DECODE;
            DECODE:
               if (!condex || !op_ok) state <= FETCH;
               else if (op == 2'b00) state <= ibit ? EXEC_I : EXEC_R;
               else if (op == 2'b01) state <= MEM_ADR;
               else state <= BRANCH;
            EXEC_R, EXEC_I:
               if (!cmd_ok) begin
                  state <= FETCH;
               end else begin
                  if (sbit || is_cmp) nzcv <= ALUFlags;
                  state <= is_cmp ? FETCH : ALU_WB;
               end
            ALU_WB:  state <= FETCH;
            MEM_ADR: state <= sbit ? MEM_RD : MEM_WR;
            MEM_RD:
               if (mem_ready) state <= MEM_WB;
            MEM_WB:  state <= FETCH;
            MEM_WR:
               if (mem_ready) state <= FETCH;
            BRANCH:  state <= FETCH;
            default: state <= FETCH;
         endcase
      end
   end

   logic       pcw_d, irw_d, adr_d, mw_d, m2r_d, srca_d;
   logic [1:0] srcb_d, imm_d, regsrc_d;
   logic       rw_d, sh_d, ill_d;
   logic [2:0] alu_d;

   always_comb begin
      pcw_d    = 1'b0;
      irw_d    = 1'b0;
      adr_d    = 1'b0;
      mw_d     = 1'b0;
      m2r_d    = 1'b0;
      srca_d   = 1'b0;
      srcb_d   = 2'b00;
      imm_d    = 2'b00;
      regsrc_d = 2'b00;
      rw_d     = 1'b0;
      sh_d     = 1'b0;
      ill_d    = 1'b0;
      alu_d    = 3'b000;
      unique case (state)
         FETCH: begin
            pcw_d  = mem_ready;
            irw_d  = mem_ready;
            srca_d = 1'b1;
            srcb_d = 2'b10;
         end
         DECODE:
            ill_d = condex && !op_ok;
         EXEC_R, EXEC_I: begin
            srcb_d = (state == EXEC_I) ? 2'b01 : 2'b00;
            alu_d  = alu_op;
            sh_d   = is_mov;
            ill_d  = !cmd_ok;
         end
         ALU_WB: begin
            rw_d = 1'b1;
            sh_d = is_mov;
         end
         MEM_ADR: begin
            srcb_d   = 2'b01;
            imm_d    = 2'b01;
            regsrc_d = sbit ? 2'b00 : 2'b10;
         end
         MEM_RD:
            adr_d = 1'b1;
         MEM_WB: begin
            rw_d  = 1'b1;
            m2r_d = 1'b1;
         end
         MEM_WR: begin
            adr_d    = 1'b1;
            regsrc_d = 2'b10;
            mw_d     = 1'b1;
         end
         BRANCH: begin
            srca_d = 1'b1;
            srcb_d = 2'b01;
            imm_d  = 2'b10;
            pcw_d  = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset forces outputs low combinationally so aborts are immediate.
   assign PCWrite    = rst_n & pcw_d;
   assign IRWrite    = rst_n & irw_d;
   assign AdrSrc     = rst_n & adr_d;
   assign MemWrite   = rst_n & mw_d;
   assign MemtoReg   = rst_n & m2r_d;
   assign ALUSrcA    = rst_n & srca_d;
   assign ALUSrcB    = rst_n ? srcb_d : 2'b00;
   assign ImmSrc     = rst_n ? imm_d : 2'b00;
   assign RegSrc     = rst_n ? regsrc_d : 2'b00;
   assign RegWrite   = rst_n & rw_d;
   assign shiftSrc   = rst_n & sh_d;
   assign illegal    = rst_n & ill_d;
   assign ALUControl = rst_n ? ALUCTRL_W'(alu_d) : '0;
   assign flags      = nzcv;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control
// words queued at drive time and checked at the falling edge.
module tb_multicycle_controller;

   logic        clk;
   logic        rst_n;
   logic [31:0] inst;
   logic [3:0]  ALUFlags;
   logic        mem_ready;
   logic        PCWrite, IRWrite, AdrSrc, MemWrite, MemtoReg, ALUSrcA;
   logic [1:0]  ALUSrcB, ImmSrc, RegSrc;
   logic        RegWrite, shiftSrc, illegal;
   logic [2:0]  ALUControl;
   logic [3:0]  flags;

   multicycle_controller dut (
      .clk(clk), .rst_n(rst_n), .inst(inst),
      .ALUFlags(ALUFlags), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
      .RegWrite(RegWrite), .shiftSrc(shiftSrc),
      .ALUControl(ALUControl), .flags(flags), .illegal(illegal)
   );

   typedef struct packed {
      logic       pcw, irw, adr, mw, m2r, srca;
      logic [1:0] srcb, imm, regsrc;
      logic       rw, sh;
      logic [2:0] alu;
      logic [3:0] fl;
      logic       ill;
   } ctl_t;

   ctl_t obs;
   assign obs = {PCWrite, IRWrite, AdrSrc, MemWrite, MemtoReg, ALUSrcA,
                 ALUSrcB, ImmSrc, RegSrc, RegWrite, shiftSrc,
                 ALUControl, flags, illegal};

   ctl_t  expq[$];
   string tagq[$];
   int    total = 0;
   int    bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d", total);
      $fatal(1, "timeout");
   end

   function automatic ctl_t zw(input logic [3:0] f);
      ctl_t c;
      c = '0;
      c.fl = f;
      return c;
   endfunction

   function automatic ctl_t fe(input logic mr, input logic [3:0] f);
      ctl_t c = zw(f);
      c.pcw = mr; c.irw = mr; c.srca = 1'b1; c.srcb = 2'b10;
      return c;
   endfunction

   function automatic ctl_t de(input logic [3:0] f, input logic il);
      ctl_t c = zw(f);
      c.ill = il;
      return c;
   endfunction

   function automatic ctl_t ex(input logic im, input logic [2:0] a,
                               input logic s, input logic il,
                               input logic [3:0] f);
      ctl_t c = zw(f);
      c.srcb = im ? 2'b01 : 2'b00;
      c.alu = a; c.sh = s; c.ill = il;
      return c;
   endfunction

   function automatic ctl_t wb(input logic s, input logic [3:0] f);
      ctl_t c = zw(f);
      c.rw = 1'b1; c.sh = s;
      return c;
   endfunction

   function automatic ctl_t ma(input logic st, input logic [3:0] f);
      ctl_t c = zw(f);
      c.srcb = 2'b01; c.imm = 2'b01;
      c.regsrc = st ? 2'b10 : 2'b00;
      return c;
   endfunction

   function automatic ctl_t mrd(input logic [3:0] f);
      ctl_t c = zw(f);
      c.adr = 1'b1;
      return c;
   endfunction

   function automatic ctl_t mwb(input logic [3:0] f);
      ctl_t c = zw(f);
      c.rw = 1'b1; c.m2r = 1'b1;
      return c;
   endfunction

   function automatic ctl_t mwr(input logic [3:0] f);
      ctl_t c = zw(f);
      c.adr = 1'b1; c.regsrc = 2'b10; c.mw = 1'b1;
      return c;
   endfunction

   function automatic ctl_t br(input logic [3:0] f);
      ctl_t c = zw(f);
      c.srca = 1'b1; c.srcb = 2'b01; c.imm = 2'b10; c.pcw = 1'b1;
      return c;
   endfunction

   // Queue the expectation, check at the falling edge, then step a cycle.
   task automatic cyc(input string tag, input ctl_t e);
      ctl_t  x;
      string t;
      expq.push_back(e);
      tagq.push_back(tag);
      @(negedge clk);
      x = expq.pop_front();
      t = tagq.pop_front();
      total++;
      assert (obs === x) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", t, obs, x);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      inst = 32'h0;
      mem_ready = 1'b1;
      ALUFlags = 4'h0;
      @(posedge clk);
      #1;
      cyc("reset", zw(4'h0));
      rst_n = 1'b1;

      inst = 32'hE0821003;
      ALUFlags = 4'hF;
      cyc("add_fetch", fe(1'b1, 4'h0));
      cyc("add_dec", de(4'h0, 1'b0));
      cyc("add_exec", ex(1'b0, 3'b000, 1'b0, 1'b0, 4'h0));
      cyc("add_wb", wb(1'b0, 4'h0));

      inst = 32'hE1510001;
      ALUFlags = 4'b0100;
      cyc("cmp_fetch", fe(1'b1, 4'h0));
      cyc("cmp_dec", de(4'h0, 1'b0));
      cyc("cmp_exec", ex(1'b0, 3'b001, 1'b0, 1'b0, 4'h0));

      inst = 32'h0A000002;
      cyc("beq_fetch", fe(1'b1, 4'h4));
      cyc("beq_dec", de(4'h4, 1'b0));
      cyc("beq_branch", br(4'h4));

      inst = 32'hE2911001;
      ALUFlags = 4'h0;
      cyc("adds_fetch", fe(1'b1, 4'h4));
      cyc("adds_dec", de(4'h4, 1'b0));
      cyc("adds_exec", ex(1'b1, 3'b000, 1'b0, 1'b0, 4'h4));
      cyc("adds_wb", wb(1'b0, 4'h0));

      inst = 32'h0A000002;
      cyc("beqn_fetch", fe(1'b1, 4'h0));
      cyc("beqn_dec", de(4'h0, 1'b0));

      inst = 32'hE5912004;
      cyc("ldr_fetch", fe(1'b1, 4'h0));
      cyc("ldr_dec", de(4'h0, 1'b0));
      cyc("ldr_adr", ma(1'b0, 4'h0));
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("ldr_rd_wait", mrd(4'h0));
      mem_ready = 1'b1;
      cyc("ldr_rd", mrd(4'h0));
      cyc("ldr_wb", mwb(4'h0));

      inst = 32'hE5812004;
      mem_ready = 1'b0;
      cyc("str_fetch_wait", fe(1'b0, 4'h0));
      mem_ready = 1'b1;
      cyc("str_fetch", fe(1'b1, 4'h0));
      cyc("str_dec", de(4'h0, 1'b0));
      cyc("str_adr", ma(1'b1, 4'h0));
      cyc("str_wr", mwr(4'h0));

      inst = 32'hE1A01002;
      cyc("mov_fetch", fe(1'b1, 4'h0));
      cyc("mov_dec", de(4'h0, 1'b0));
      cyc("mov_exec", ex(1'b0, 3'b000, 1'b1, 1'b0, 4'h0));
      cyc("mov_wb", wb(1'b1, 4'h0));

      inst = 32'hEC000000;
      cyc("op11_fetch", fe(1'b1, 4'h0));
      cyc("op11_dec", de(4'h0, 1'b1));

      inst = 32'hE0F00000;
      ALUFlags = 4'hF;
      cyc("bad_fetch", fe(1'b1, 4'h0));
      cyc("bad_dec", de(4'h0, 1'b0));
      cyc("bad_exec", ex(1'b0, 3'b000, 1'b0, 1'b1, 4'h0));

      inst = 32'h00821003;
      cyc("addeq_fetch", fe(1'b1, 4'h0));
      cyc("addeq_dec", de(4'h0, 1'b0));

      inst = 32'hE1510001;
      ALUFlags = 4'b1010;
      cyc("cmp2_fetch", fe(1'b1, 4'h0));
      cyc("cmp2_dec", de(4'h0, 1'b0));
      cyc("cmp2_exec", ex(1'b0, 3'b001, 1'b0, 1'b0, 4'h0));

      inst = 32'hE5812004;
      cyc("str2_fetch", fe(1'b1, 4'hA));
      cyc("str2_dec", de(4'hA, 1'b0));
      cyc("str2_adr", ma(1'b1, 4'hA));
      mem_ready = 1'b0;
      cyc("str2_wr_wait", mwr(4'hA));
      rst_n = 1'b0;
      cyc("str2_reset", zw(4'h0));
      rst_n = 1'b1;
      mem_ready = 1'b1;

      inst = 32'h0A000002;
      cyc("post_fetch", fe(1'b1, 4'h0));
      cyc("post_dec", de(4'h0, 1'b0));
      cyc("post_fetch2", fe(1'b1, 4'h0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multicycle successor to the single-cycle instruction decoder. Holds an FSM that sequences fetch, decode, execute, memory and writeback over several cycles and keeps an internal NZCV flag register. It gates every instruction on the ARM condition field and stalls memory states on a ready handshake. It sits between the instruction register and the shared datapath (ALU, register file, unified memory, PC).

## Interface
- `ALUCTRL_W`, default 3: width of `ALUControl`.
- `COND_EN`, default 1: 1 enables condition checking; 0 makes every instruction execute.
- `BRANCH_EN`, default 1: 1 enables the branch path; 0 makes op=10 illegal.
- `clk` input 1: single clock, all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `inst` input 32: instruction register contents; valid from Decode onward.
- `ALUFlags` input 4: {N,Z,C,V} from the ALU, sampled in execute states.
- `mem_ready` input 1: memory completes the access in the current cycle.
- `PCWrite` output 1: load the PC.
- `IRWrite` output 1: load the instruction register.
- `AdrSrc` output 1: memory address source, 0=PC, 1=ALU result register.
- `MemWrite` output 1: memory write strobe.
- `MemtoReg` output 1: writeback source, 1=memory data.
- `ALUSrcA` output 1: ALU A operand, 1=PC, 0=Rn.
- `ALUSrcB` output 2: ALU B operand, 00=Rm, 01=extended immediate, 10=constant 4.
- `ImmSrc` output 2: immediate format, 00=imm8 data-processing, 01=imm12 load/store, 10=imm24 branch.
- `RegSrc` output 2: bit0=1 reads R15; bit1=1 reads Rd as the second source (store).
- `RegWrite` output 1: register file write enable.
- `shiftSrc` output 1: result comes from the shifter (MOV/LSL/LSR).
- `ALUControl` output ALUCTRL_W: ALU operation; the upper bits above [2:0] are zero.
- `flags` output 4: current NZCV register.
- `illegal` output 1: one-cycle pulse on an undecodable instruction.

## Operation
- FSM states: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH.
- FETCH:
  - Drive AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, PCWrite=1.
  - Hold in FETCH while mem_ready=0; IRWrite and PCWrite assert only in the cycle mem_ready=1.
  - Advance to DECODE.
- DECODE:
  - Evaluate CondEx from inst[31:28] against `flags`, using the standard ARM codes 0000 EQ through 1110 AL. 1111 counts as true.
  - CondEx=0 goes to FETCH with no side effects.
  - op=00: I bit inst[25]=1 goes to EXEC_I, else EXEC_R.
  - op=01 goes to MEM_ADR.
  - op=10 with BRANCH_EN goes to BRANCH.
  - Otherwise pulse `illegal` and go to FETCH.
- EXEC_R/EXEC_I:
  - Drive ALUSrcA=0, with ALUSrcB=00 (R) or 01 (I) and ImmSrc=00.
  - cmd→ALUControl: 0100→000, 0010→001, 0000→100, 1100→101, 1010 (CMP)→001, 1101 (MOV)→000 with shiftSrc=1.
  - Latch ALUFlags into `flags` at the end of the cycle if inst[20]=1 or cmd=CMP.
  - CMP goes to FETCH.
  - Unsupported cmd pulses `illegal`, leaves flags unchanged, and goes to FETCH with no RegWrite. This differs deliberately from the old default, which wrote.
  - All other cmds go to ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0, shiftSrc held from execute. Go to FETCH.
- MEM_ADR:
  - Drive ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ALUControl=000.
  - L=1 (load) goes to MEM_RD; L=0 (store) goes to MEM_WR with RegSrc=10.
- MEM_RD: AdrSrc=1. Hold while mem_ready=0; on mem_ready=1 go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1. Go to FETCH.
- MEM_WR:
  - Drive AdrSrc=1 and RegSrc=10.
  - MemWrite=1 every cycle while in this state; the write is taken on the cycle with mem_ready=1.
  - On mem_ready=1 go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=01, ImmSrc=10, ALUControl=000, PCWrite=1. Go to FETCH.
- Inactive outputs are 0 in every state. Outputs are decoded from state plus `inst` (Moore plus instruction fields); the only Mealy term is mem_ready gating PCWrite/IRWrite.
- When COND_EN=0, CondEx is forced to 1.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=FETCH, flags=0000.
  - Every output is 0 while rst_n is low, except `flags`, which reads 0000.
- First FETCH strobe: the first rising edge after rst_n deasserts.
- Cycles per instruction with zero-wait memory:
  - data-processing 4 (CMP 3)
  - LDR 5
  - STR 4
  - B 3
  - failed condition 2
- Each cycle with mem_ready=0 in FETCH/MEM_RD/MEM_WR adds one cycle.
- Flags latched in EXEC_* become visible to the next instruction's DECODE.
- Reset mid-instruction aborts immediately with no partial RegWrite/MemWrite. Flags clear.
- `illegal` is exactly one cycle wide, in DECODE or EXEC_*.

## Test plan
- ADD R1,R2,R3 (0xE0821003), mem_ready=1: states FETCH→DECODE→EXEC_R→ALU_WB→FETCH. ALUControl=000 in EXEC_R, RegWrite=1 only in ALU_WB.
- CMP then BEQ:
  - CMP R1,R1 with ALUFlags=0100: flags=0100 after EXEC_R, RegWrite never asserts.
  - Following BEQ (0x0A000002): reaches BRANCH with PCWrite=1 and ImmSrc=10.
  - Same BEQ with flags=0000: returns to FETCH after DECODE.
- LDR (0xE5912004) with mem_ready low for 3 cycles in MEM_RD: AdrSrc=1 held 4 cycles, then MEM_WB with MemtoReg=1 and RegWrite=1. Total 8 cycles.
- STR (0xE5812004): RegSrc=10 in MEM_ADR/MEM_WR, MemWrite=1 in MEM_WR, RegWrite=0 throughout.
- Illegal cases:
  - op=11: `illegal` pulses for 1 cycle in DECODE, then FETCH.
  - cmd=0111: `illegal` pulses in EXEC_R, with no RegWrite and flags unchanged.
- Reset asserted during MEM_WR with mem_ready=0: MemWrite drops asynchronously, flags=0000. After release, the first cycle is FETCH.
